// File: rtl/decomp_seq_ctrl.sv
// rtl/decomp_seq_ctrl.sv - block sequencer for the word decompressor datapath
//
// Accepts compressed or raw 128-bit beats and drives the decompressor datapath
// (enable / update / compression flag / flush). Decompressed lines, or raw
// beats in bypass, are collected into a single-entry output register.
//
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-low reset
//   i_in_valid/o_in_ready/i_in_data input beat stream, i_in_comp = block type
//   o_dp_en/o_dp_update/o_dp_comp_flag/o_dp_data/o_dp_flush  datapath controls
//   i_dp_need/i_dp_line_valid/i_dp_line  datapath status and decoded line
//   o_out_valid/i_out_ready/o_out_data/o_out_last  output line register
//   o_busy                          sequencer not idle
//
// Optional macro DECOMP_SEQ_STATS_EN adds o_stall_in_cnt, o_stall_out_cnt
// (saturating 16-bit stall counters) and the sticky o_proto_err flag.

module decomp_seq_ctrl #(
    parameter int WIDTH_DATA_IN = 128,
    parameter int BLOCK_LINES   = 4,
    parameter int FILL_BEATS    = 2,
    parameter int CNT_W         = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH_DATA_IN-1:0] i_in_data,
    input  logic                     i_in_comp,
    output logic                     o_dp_en,
    output logic                     o_dp_update,
    output logic                     o_dp_comp_flag,
    output logic [WIDTH_DATA_IN-1:0] o_dp_data,
    output logic                     o_dp_flush,
    input  logic                     i_dp_need,
    input  logic                     i_dp_line_valid,
    input  logic [WIDTH_DATA_IN-1:0] i_dp_line,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH_DATA_IN-1:0] o_out_data,
    output logic                     o_out_last,
    output logic                     o_busy
`ifdef DECOMP_SEQ_STATS_EN
    ,
    output logic [15:0]              o_stall_in_cnt,
    output logic [15:0]              o_stall_out_cnt,
    output logic                     o_proto_err
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_BYPASS = 3'd4;

    logic [2:0]               state_q, state_d;
    logic                     comp_q, comp_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]         line_cnt_q, line_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [WIDTH_DATA_IN-1:0] out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     flush_q, flush_d;

    logic                     hold;
    logic                     line_last;
    logic                     in_ready;
    logic                     dp_en;
    logic                     dp_update;
    logic                     cap;
    logic                     last_cap;
    logic [WIDTH_DATA_IN-1:0] cap_data;

    // The output register cannot take a new line while a consumer is stalling it.
    assign hold      = out_valid_q & ~i_out_ready;
    assign line_last = (line_cnt_q == CNT_W'(BLOCK_LINES - 1));

    always_comb begin
        state_d    = state_q;
        comp_d     = comp_q;
        beat_cnt_d = beat_cnt_q;
        line_cnt_d = line_cnt_q;
        flush_d    = 1'b0;
        in_ready   = 1'b0;
        dp_en      = 1'b0;
        dp_update  = 1'b0;
        cap        = 1'b0;
        last_cap   = 1'b0;
        cap_data   = i_dp_line;

        case (state_q)
            ST_IDLE: begin
                // Only the block type is sampled here; the beat itself is
                // consumed by FILL or BYPASS on the following cycle.
                if (i_in_valid) begin
                    comp_d  = i_in_comp;
                    state_d = i_in_comp ? ST_FILL : ST_BYPASS;
                end
            end
            ST_FILL: begin
                in_ready  = i_in_valid;
                dp_en     = i_in_valid;
                dp_update = i_in_valid;
                if (i_in_valid) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(FILL_BEATS - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cap      = i_dp_line_valid & ~hold;
                last_cap = cap & line_last;
                // Stop the datapath on the last line so no beat of the next
                // block is pulled into this block's window.
                dp_en     = ~hold & (~i_dp_need | i_in_valid) & ~last_cap;
                dp_update = dp_en & i_dp_need;
                in_ready  = dp_update;
                cap_data  = i_dp_line;
                if (cap) begin
                    line_cnt_d = line_cnt_q + CNT_W'(1);
                end
                if (last_cap) begin
                    state_d = ST_DRAIN;
                    flush_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && i_out_ready) begin
                    state_d    = ST_IDLE;
                    comp_d     = 1'b0;
                    beat_cnt_d = '0;
                    line_cnt_d = '0;
                end
            end
            ST_BYPASS: begin
                in_ready = ~out_valid_q | i_out_ready;
                cap      = in_ready & i_in_valid;
                cap_data = i_in_data;
                if (cap) begin
                    line_cnt_d = line_cnt_q + CNT_W'(1);
                    if (line_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Single-entry output register; a capture wins over a consume.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (cap) begin
            out_valid_d = 1'b1;
            out_data_d  = cap_data;
            out_last_d  = line_last;
        end else if (out_valid_q && i_out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            comp_q      <= 1'b0;
            beat_cnt_q  <= '0;
            line_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            comp_q      <= comp_d;
            beat_cnt_q  <= beat_cnt_d;
            line_cnt_q  <= line_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            flush_q     <= flush_d;
        end
    end

    assign o_in_ready     = in_ready;
    assign o_dp_en        = dp_en;
    assign o_dp_update    = dp_update;
    assign o_dp_comp_flag = comp_q & ((state_q == ST_FILL) | (state_q == ST_RUN) |
                                      (state_q == ST_DRAIN));
    assign o_dp_data      = i_in_data;
    assign o_dp_flush     = flush_q;
    assign o_out_valid    = out_valid_q;
    assign o_out_data     = out_data_q;
    assign o_out_last     = out_last_q;
    assign o_busy         = (state_q != ST_IDLE);

`ifdef DECOMP_SEQ_STATS_EN
    logic [15:0] stall_in_cnt_q, stall_in_cnt_d;
    logic [15:0] stall_out_cnt_q, stall_out_cnt_d;
    logic        proto_err_q, proto_err_d;
    logic        run_st;

    assign run_st = (state_q == ST_RUN);

    always_comb begin
        stall_in_cnt_d  = stall_in_cnt_q;
        stall_out_cnt_d = stall_out_cnt_q;
        proto_err_d     = proto_err_q;
        if (run_st && i_dp_need && !i_in_valid && (stall_in_cnt_q != 16'hFFFF)) begin
            stall_in_cnt_d = stall_in_cnt_q + 16'd1;
        end
        if (run_st && hold && (stall_out_cnt_q != 16'hFFFF)) begin
            stall_out_cnt_d = stall_out_cnt_q + 16'd1;
        end
        // A line offered while the output register is stalled is lost.
        if (run_st && hold && i_dp_line_valid) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_in_cnt_q  <= 16'd0;
            stall_out_cnt_q <= 16'd0;
            proto_err_q     <= 1'b0;
        end else begin
            stall_in_cnt_q  <= stall_in_cnt_d;
            stall_out_cnt_q <= stall_out_cnt_d;
            proto_err_q     <= proto_err_d;
        end
    end

    assign o_stall_in_cnt  = stall_in_cnt_q;
    assign o_stall_out_cnt = stall_out_cnt_q;
    assign o_proto_err     = proto_err_q;
`endif

endmodule

// File: tb/tb_decomp_seq_ctrl.sv
// tb/tb_decomp_seq_ctrl.sv - self-checking bench for decomp_seq_ctrl

module tb_decomp_seq_ctrl;

    logic         i_clk;
    logic         i_reset;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [127:0] i_in_data;
    logic         i_in_comp;
    logic         o_dp_en;
    logic         o_dp_update;
    logic         o_dp_comp_flag;
    logic [127:0] o_dp_data;
    logic         o_dp_flush;
    logic         i_dp_need;
    logic         i_dp_line_valid;
    logic [127:0] i_dp_line;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [127:0] o_out_data;
    logic         o_out_last;
    logic         o_busy;
`ifdef DECOMP_SEQ_STATS_EN
    logic [15:0]  o_stall_in_cnt;
    logic [15:0]  o_stall_out_cnt;
    logic         o_proto_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [128:0] exp_q[$];

    decomp_seq_ctrl dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_in_data      (i_in_data),
        .i_in_comp      (i_in_comp),
        .o_dp_en        (o_dp_en),
        .o_dp_update    (o_dp_update),
        .o_dp_comp_flag (o_dp_comp_flag),
        .o_dp_data      (o_dp_data),
        .o_dp_flush     (o_dp_flush),
        .i_dp_need      (i_dp_need),
        .i_dp_line_valid(i_dp_line_valid),
        .i_dp_line      (i_dp_line),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_data     (o_out_data),
        .o_out_last     (o_out_last),
        .o_busy         (o_busy)
`ifdef DECOMP_SEQ_STATS_EN
        ,
        .o_stall_in_cnt (o_stall_in_cnt),
        .o_stall_out_cnt(o_stall_out_cnt),
        .o_proto_err    (o_proto_err)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake on the output consumes one expectation.
    always @(negedge i_clk) begin
        logic [128:0] e;
        if (i_reset && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got line %h expected none", o_out_data);
            end else begin
                e = exp_q.pop_front();
                chk("mon_data", o_out_data, e[127:0]);
                chk("mon_last", {127'd0, o_out_last}, {127'd0, e[128]});
            end
        end
    end

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycle(input logic comp, input logic [127:0] d);
        i_in_valid      = 1'b1;
        i_in_comp       = comp;
        i_in_data       = d;
        i_dp_need       = 1'b0;
        i_dp_line_valid = 1'b0;
        @(negedge i_clk);
        chk("idle_in_ready", {127'd0, o_in_ready}, 128'd0);
        chk("idle_busy", {127'd0, o_busy}, 128'd0);
        nxt();
    endtask

    task automatic idle_quiet();
        i_in_valid      = 1'b0;
        i_dp_need       = 1'b0;
        i_dp_line_valid = 1'b0;
        @(negedge i_clk);
        chk("quiet_busy", {127'd0, o_busy}, 128'd0);
        chk("quiet_out_valid", {127'd0, o_out_valid}, 128'd0);
        chk("quiet_flush", {127'd0, o_dp_flush}, 128'd0);
        chk("quiet_comp_flag", {127'd0, o_dp_comp_flag}, 128'd0);
        nxt();
    endtask

    task automatic fill_beats(input logic [127:0] b0, input logic [127:0] b1);
        for (int k = 0; k < 2; k++) begin
            i_in_valid = 1'b1;
            i_in_data  = (k == 0) ? b0 : b1;
            @(negedge i_clk);
            chk("fill_in_ready", {127'd0, o_in_ready}, 128'd1);
            chk("fill_update", {127'd0, o_dp_update}, 128'd1);
            chk("fill_en", {127'd0, o_dp_en}, 128'd1);
            chk("fill_comp_flag", {127'd0, o_dp_comp_flag}, 128'd1);
            chk("fill_dp_data", o_dp_data, (k == 0) ? b0 : b1);
            nxt();
        end
    endtask

    task automatic run_vec(input logic v, input logic n, input logic lv, input logic rdy,
                           input logic [127:0] line, input logic exp_en, input logic exp_upd,
                           input logic push, input logic last, input string name);
        i_in_valid      = v;
        i_dp_need       = n;
        i_dp_line_valid = lv;
        i_dp_line       = line;
        i_out_ready     = rdy;
        if (push) exp_q.push_back({last, line});
        @(negedge i_clk);
        chk({name, "_en"}, {127'd0, o_dp_en}, {127'd0, exp_en});
        chk({name, "_upd"}, {127'd0, o_dp_update}, {127'd0, exp_upd});
        chk({name, "_in_ready"}, {127'd0, o_in_ready}, {127'd0, exp_upd});
        nxt();
    endtask

    task automatic drain_check(input logic exp_flush);
        i_dp_line_valid = 1'b0;
        i_dp_need       = 1'b0;
        i_out_ready     = 1'b1;
        @(negedge i_clk);
        chk("drain_flush", {127'd0, o_dp_flush}, {127'd0, exp_flush});
        chk("drain_en", {127'd0, o_dp_en}, 128'd0);
        chk("drain_in_ready", {127'd0, o_in_ready}, 128'd0);
        chk("drain_out_valid", {127'd0, o_out_valid}, 128'd1);
        chk("drain_out_last", {127'd0, o_out_last}, 128'd1);
        chk("drain_busy", {127'd0, o_busy}, 128'd1);
        nxt();
    endtask

    task automatic bypass_block(input logic [127:0] base);
        logic [127:0] beat;
        idle_cycle(1'b0, base);
        for (int k = 0; k < 4; k++) begin
            beat        = base + 128'(k);
            i_in_valid  = 1'b1;
            i_in_comp   = (k != 0);
            i_in_data   = beat;
            i_out_ready = 1'b1;
            exp_q.push_back({(k == 3), beat});
            @(negedge i_clk);
            chk("byp_in_ready", {127'd0, o_in_ready}, 128'd1);
            chk("byp_en", {127'd0, o_dp_en}, 128'd0);
            chk("byp_comp_flag", {127'd0, o_dp_comp_flag}, 128'd0);
            if (k > 0) begin
                chk("byp_lat_valid", {127'd0, o_out_valid}, 128'd1);
                chk("byp_lat_data", o_out_data, base + 128'(k - 1));
                chk("byp_lat_last", {127'd0, o_out_last}, 128'd0);
            end
            nxt();
        end
        i_in_valid = 1'b0;
        i_in_comp  = 1'b0;
        drain_check(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset         = 1'b0;
        i_in_valid      = 1'b0;
        i_in_data       = '0;
        i_in_comp       = 1'b0;
        i_dp_need       = 1'b0;
        i_dp_line_valid = 1'b0;
        i_dp_line       = '0;
        i_out_ready     = 1'b0;

        // Reset state
        @(negedge i_clk);
        chk("rst_in_ready", {127'd0, o_in_ready}, 128'd0);
        chk("rst_en", {127'd0, o_dp_en}, 128'd0);
        chk("rst_upd", {127'd0, o_dp_update}, 128'd0);
        chk("rst_comp_flag", {127'd0, o_dp_comp_flag}, 128'd0);
        chk("rst_flush", {127'd0, o_dp_flush}, 128'd0);
        chk("rst_out_valid", {127'd0, o_out_valid}, 128'd0);
        chk("rst_out_data", o_out_data, 128'd0);
        chk("rst_out_last", {127'd0, o_out_last}, 128'd0);
        chk("rst_busy", {127'd0, o_busy}, 128'd0);
        nxt();
        nxt();
        i_reset = 1'b1;

        // Bypass block 0xA..0xD
        bypass_block(128'hA);
        idle_quiet();

        // Compressed block, ready always high
        idle_cycle(1'b1, 128'hF0);
        fill_beats(128'hF0, 128'hF1);
        run_vec(1, 0, 0, 1, 128'h0,     1, 0, 0, 0, "c_r0");
        run_vec(1, 1, 0, 1, 128'h0,     1, 1, 0, 0, "c_r1");
        run_vec(1, 0, 1, 1, 128'hC100,  1, 0, 1, 0, "c_r2");
        run_vec(1, 1, 1, 1, 128'hC101,  1, 1, 1, 0, "c_r3");
        run_vec(0, 0, 1, 1, 128'hC102,  1, 0, 1, 0, "c_r4");
        run_vec(1, 1, 1, 1, 128'hC103,  0, 0, 1, 1, "c_r5");
        i_in_valid = 1'b0;
        drain_check(1'b1);
        idle_quiet();

        // Reset mid-RUN with a line parked in the output register
        idle_cycle(1'b1, 128'hE0);
        fill_beats(128'hE0, 128'hE1);
        run_vec(1, 1, 0, 1, 128'h0,    1, 1, 0, 0, "r_r0");
        run_vec(1, 0, 1, 0, 128'hDEAD, 1, 0, 0, 0, "r_r1");
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_in_valid      = 1'b0;
            i_dp_line_valid = 1'b0;
            i_dp_need       = 1'b0;
            @(negedge i_clk);
            chk("mid_rst_busy", {127'd0, o_busy}, 128'd0);
            chk("mid_rst_out_valid", {127'd0, o_out_valid}, 128'd0);
            chk("mid_rst_out_data", o_out_data, 128'd0);
            chk("mid_rst_flush", {127'd0, o_dp_flush}, 128'd0);
            chk("mid_rst_en", {127'd0, o_dp_en}, 128'd0);
            chk("mid_rst_comp_flag", {127'd0, o_dp_comp_flag}, 128'd0);
            nxt();
        end
        i_reset     = 1'b1;
        i_out_ready = 1'b1;
        idle_quiet();

        // Starvation and backpressure
        idle_cycle(1'b1, 128'hB0);
        fill_beats(128'hB0, 128'hB1);
        for (int k = 0; k < 5; k++) begin
            run_vec(0, 1, 0, 1, 128'h0, 0, 0, 0, 0, "starve");
        end
        run_vec(1, 1, 0, 1, 128'h0,    1, 1, 0, 0, "resume");
        run_vec(1, 0, 1, 1, 128'hD200, 1, 0, 1, 0, "bp_l0");
        for (int k = 0; k < 6; k++) begin
            i_in_valid      = 1'b1;
            i_dp_need       = 1'b1;
            i_dp_line_valid = 1'b0;
            i_out_ready     = 1'b0;
            @(negedge i_clk);
            chk("bp_en", {127'd0, o_dp_en}, 128'd0);
            chk("bp_out_valid", {127'd0, o_out_valid}, 128'd1);
            chk("bp_out_data", o_out_data, 128'hD200);
            nxt();
        end
        run_vec(1, 1, 1, 1, 128'hD201, 1, 1, 1, 0, "bp_l1");
        run_vec(1, 0, 1, 1, 128'hD202, 1, 0, 1, 0, "bp_l2");
        run_vec(1, 0, 1, 1, 128'hD203, 0, 0, 1, 1, "bp_l3");
        i_in_valid = 1'b0;
        drain_check(1'b1);
        idle_quiet();
`ifdef DECOMP_SEQ_STATS_EN
        chk("stall_in_cnt", {112'd0, o_stall_in_cnt}, 128'd5);
        chk("stall_out_cnt", {112'd0, o_stall_out_cnt}, 128'd6);
        chk("proto_err", {127'd0, o_proto_err}, 128'd0);
`endif

        // Back-to-back: compressed then bypass with input valid held high
        idle_cycle(1'b1, 128'h70);
        fill_beats(128'h70, 128'h71);
        i_in_data = 128'h100;
        i_in_comp = 1'b0;
        run_vec(1, 0, 1, 1, 128'h9900, 1, 0, 1, 0, "bb_l0");
        run_vec(1, 0, 1, 1, 128'h9901, 1, 0, 1, 0, "bb_l1");
        run_vec(1, 0, 1, 1, 128'h9902, 1, 0, 1, 0, "bb_l2");
        run_vec(1, 0, 1, 1, 128'h9903, 0, 0, 1, 1, "bb_l3");
        drain_check(1'b1);
        bypass_block(128'h100);
        idle_quiet();

        repeat (3) nxt();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decomp_seq_ctrl.md
Name: decomp_seq_ctrl

Overview:
- Block-level sequencer for the word decompressor datapath.
- Accepts 128-bit compressed or raw beats on a valid/ready stream and drives the datapath's enable, update and compression-flag inputs.
- Stalls the datapath on input starvation or output backpressure, and collects decompressed 128-bit lines into a single-entry output register with valid/ready.
- Sits between the cache-line fetch buffer and the line fill port.

Parameters:
- WIDTH_DATA_IN, 128, beat and line width in bits.
- BLOCK_LINES, 4, decompressed lines per block (16 words of 32 bits).
- FILL_BEATS, 2, beats preloaded into the bit window before decoding starts.
- CNT_W, 3, width of the line and beat counters; must hold BLOCK_LINES.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_in_valid  in  1  input beat valid.
- o_in_ready  out  1  input beat accepted this cycle.
- i_in_data  in  128  compressed or raw beat.
- i_in_comp  in  1  block is compressed; sampled on the block's first beat only.
- o_dp_en  out  1  datapath enable (decompressor_en).
- o_dp_update  out  1  load the current beat into the datapath window (update).
- o_dp_comp_flag  out  1  datapath output mux select; 1 means decompressed line.
- o_dp_data  out  128  beat forwarded to the datapath.
- o_dp_flush  out  1  one-cycle pulse that clears the datapath window at block end.
- i_dp_need  in  1  datapath requests a new beat (window below threshold).
- i_dp_line_valid  in  1  datapath has a complete 128-bit line.
- i_dp_line  in  128  decompressed line.
- o_out_valid  out  1  output line valid.
- i_out_ready  in  1  consumer accepts the line.
- o_out_data  out  128  output line.
- o_out_last  out  1  final line of the block.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (i_reset low, asynchronous): FSM to IDLE; all counters 0; every output 0, including o_out_data.
- States:
  - IDLE: o_in_ready=0.
    - i_in_valid with i_in_comp=1: latch comp=1, go to FILL.
    - i_in_valid with i_in_comp=0: go to BYPASS.
    - The beat is not consumed in IDLE.
  - FILL: o_in_ready = o_dp_update = o_dp_en = i_in_valid.
    - beat_cnt increments per accepted beat.
    - At beat_cnt == FILL_BEATS-1 with an accepted beat, go to RUN.
    - No beat available: all three outputs 0 (hold).
  - RUN: hold = o_out_valid & ~i_out_ready.
    - o_dp_en = ~hold & (~i_dp_need | i_in_valid).
    - o_dp_update = o_in_ready = o_dp_en & i_dp_need.
    - On i_dp_line_valid: o_out_data <= i_dp_line, o_out_valid <= 1, line_cnt += 1, o_out_last = (line_cnt == BLOCK_LINES-1).
    - When the last line is captured: go to DRAIN, pulse o_dp_flush, o_dp_en=0.
  - DRAIN: wait for the o_out_valid & i_out_ready handshake on the last line, then go to IDLE. Counters clear on that transition.
  - BYPASS: o_dp_comp_flag=0, o_dp_en=0.
    - o_in_ready = ~o_out_valid | i_out_ready.
    - Each accepted beat goes to o_out_data/o_out_valid; line_cnt increments.
    - After BLOCK_LINES beats, go to DRAIN.
- o_dp_comp_flag = 1 in FILL, RUN and DRAIN of a compressed block; 0 elsewhere.
- o_dp_data = i_in_data combinationally.
- Output register:
  - Cleared when consumed with no new capture.
  - A simultaneous consume and capture keeps o_out_valid=1 and takes the new data.
- Latency:
  - Bypass: 1 cycle from beat accept to o_out_valid.
  - Compressed: o_out_valid rises 1 cycle after i_dp_line_valid.
- Sticky error: i_dp_line_valid while hold=1 is a protocol error; the flag is held until reset. It is exposed only with the optional feature; behaviour is otherwise unchanged and the line is dropped.
- i_in_comp is ignored on every beat except the block's first.
- Reset mid-block aborts immediately; no flush pulse is issued.

Optional Feature:
- Macro DECOMP_SEQ_STATS_EN.
- When defined:
  - Adds outputs o_stall_in_cnt[15:0] (RUN cycles with i_dp_need & ~i_in_valid), o_stall_out_cnt[15:0] (RUN cycles with hold=1) and o_proto_err.
  - Counters saturate at 16'hFFFF and clear only on reset.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles mid-RUN, then release -> all outputs 0, o_busy=0; next block starts cleanly from IDLE.
- Bypass: block with i_in_comp=0, 4 beats 0xA..0xD, i_out_ready=1 -> 4 output lines in order, each 1 cycle after accept; o_out_last only on 0xD; o_dp_en never 1.
- Compressed fill: i_in_comp=1, beats always valid, i_dp_need pulses -> exactly 2 update cycles in FILL; each later update coincides with i_dp_need and i_in_valid; 4 lines captured; o_dp_flush pulses once after the 4th line.
- Input starvation: drop i_in_valid for 5 cycles while i_dp_need=1 in RUN -> o_dp_en=0 for those 5 cycles; resumes the cycle valid returns; with DECOMP_SEQ_STATS_EN, o_stall_in_cnt=5.
- Output backpressure: i_out_ready=0 for 6 cycles with the line register full -> o_dp_en=0 throughout, o_out_data stable; simultaneous ready plus new line keeps o_out_valid=1 with the new data.
- Back-to-back blocks: compressed then bypass, i_in_valid continuous -> DRAIN→IDLE→BYPASS with no beat lost; the second block's first beat is not consumed in IDLE.
